// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: serial FSM state encoding and default operand width.
package arith_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_adder_structure.sv
// 1-bit full-adder cell; the per-bit datapath of the serial adder.
module full_adder_structure (
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic cout,
  output logic sum
);
  logic w_axb;

  assign w_axb = a ^ b;
  assign sum   = w_axb ^ cin;
  assign cout  = (a & b) | (w_axb & cin);
endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
module serial_adder_nbit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh, w_s_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_done;
  logic             w_s, w_c;

  full_adder_structure u_fa (
    .cin  (r_carry),
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cout (w_c),
    .sum  (w_s)
  );

  // Sum bits enter at the MSB so the final shift leaves bit 0 in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_nxt = w_s;
    end else begin : g_wn
      assign w_s_nxt = {w_s, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (start) w_nstate = RUN;
      RUN:     if (r_cnt == LAST) w_nstate = DONE;
      DONE:    w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_s_sh  <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_nxt;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum  <= w_s_nxt;
            r_cout <= w_c;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit at WIDTH=4; expected values are hand-derived.
module tb_serial_adder_nbit;
  localparam int W = 4;

  logic         clk, rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; done must appear on the 5th negedge after the accepting edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W:0] exp, input bit full);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    for (int j = 1; j <= W + 2; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
      end
      if (full) begin
        chk($sformatf("busy j%0d", j), busy, (j <= W + 1));
        chk($sformatf("done j%0d", j), done, (j == W + 1));
      end else if (j == W + 1) begin
        chk("sweep done", done, 1);
      end
      if (j == W + 1) chk($sformatf("sum %0d+%0d+%0d", ta, tb_, tc), {cout, sum}, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd3, 4'd5, 1'b0, 5'd8, 1);
    do_op(4'd15, 4'd1, 1'b0, 5'd16, 1);
    do_op(4'd0, 4'd0, 1'b1, 5'd1, 1);
    do_op(4'd15, 4'd15, 1'b1, 5'd31, 1);
    repeat (3) @(negedge clk);
    chk("hold sum", sum, 15);
    chk("hold cout", cout, 1);
    chk("hold done", done, 0);

    // start pulsed while busy must be ignored
    a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      start = (j == 2);
      if (j == 2) begin a = 4'd7; b = 4'd7; end
      if (j == 5) begin
        chk("busy-start done", done, 1);
        chk("busy-start sum", {cout, sum}, 5'd3);
      end else begin
        chk($sformatf("no 2nd done j%0d", j), done, 0);
      end
    end
    chk("busy-start hold", {cout, sum}, 5'd3);

    // start held high: second op accepted on the first IDLE cycle
    a = 4'd1; b = 4'd1; cin = 1'b0; start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 5) chk("held op1", {done, cout, sum}, {1'b1, 5'd2});
      if (j == 6) begin
        chk("held idle busy", busy, 0);
        a = 4'd4; b = 4'd4;
      end
      if (j == 7) start = 1'b0;
      if (j == 11) chk("held op2", {done, cout, sum}, {1'b1, 5'd8});
    end
    @(negedge clk);

    // async reset mid-run
    a = 4'd9; b = 4'd9; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst sum", sum, 0);
    chk("arst cout", cout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("post-rst no done %0d", j), done, 0);
    end
    do_op(4'd2, 4'd2, 1'b0, 5'd4, 1);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          do_op(W'(ia), W'(ib), ic[0], 5'(ia + ib + ic), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
